fir_sample_source: RTL and testbench
====================================

Name: fir_sample_source

Overview:
- Upstream feeder for FIR_Filter. Holds a loadable 32-entry table of 16-bit samples.
- Streams the table onto the filter's data_in at a programmable sample rate, either once or looping.
- Replaces free-running address-counter stimulus with a controllable, restartable sample player usable in both bench and system.

Parameters:
- DATA_W, 16, sample width; matches FIR_Filter data_in.
- DEPTH, 32, table entries.
- ADDR_W, 5, log2(DEPTH).
- DIV_W, 8, width of the rate divider.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  table write strobe.
- wr_addr  in  ADDR_W  table write address.
- wr_data  in  DATA_W  table write data.
- start  in  1  begin playback; honoured in IDLE only.
- stop  in  1  abort playback.
- len_m1  in  ADDR_W  samples per pass minus 1; 0..31 means 1..32 samples.
- rate_div  in  DIV_W  one sample every rate_div+1 cycles.
- loop_en  in  1  1 = wrap to entry 0 after the last entry; 0 = single pass.
- data_out  out  DATA_W  current sample; drives FIR_Filter data_in.
- sample_strobe  out  1  one-cycle pulse: data_out updated this cycle.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse on the final sample of a non-looping pass.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - data_out=0, sample_strobe=0, busy=0, done=0.
  - Internal addr=0 and div_cnt=0.
  - Table contents are not reset and are retained across reset.
- States: IDLE, RUN.
- IDLE:
  - data_out holds its last value.
  - start=1 and stop=0 at edge N: go to RUN; capture len_m1 and rate_div into registers; addr=0; div_cnt=0.
  - start=1 and stop=1 together: stop wins; remain in IDLE.
- RUN, each cycle:
  - If stop=1: go to IDLE at this edge. No strobe, no done. data_out holds.
  - Else if div_cnt != captured rate_div: div_cnt+1.
  - Else emit:
    - data_out <= table[addr]; sample_strobe=1; div_cnt=0.
    - If addr == captured len_m1 and loop_en=1: addr=0.
    - If addr == captured len_m1 and loop_en=0: done=1 in the same cycle as the strobe; go to IDLE.
    - Otherwise addr+1.
- Latency: start sampled at edge N gives the first strobe and data_out=table[0] at edge N+1+rate_div. Subsequent samples follow every rate_div+1 cycles.
  - rate_div=0 means one sample per clock, continuous.
- loop_en is sampled live. Clearing it mid-pass makes the current pass the last.
- start while in RUN is ignored. len_m1 and rate_div changes while in RUN have no effect until the next start.
- Writes are accepted in any state.
  - A write to the entry being read on the same edge: read returns the old data (read-first).
  - The new value is seen on the next pass.
- busy = (state == RUN), registered.
- All outputs are registered; no combinational input-to-output path.
- Reset asserted mid-RUN aborts immediately: outputs 0, no done pulse.

Decomposition:
- Package fir_pkg holds:
  - DATA_W, DEPTH, ADDR_W constants (shared with FIR_Filter).
  - typedef logic [DATA_W-1:0] sample_t.
  - typedef enum {IDLE, RUN} src_state_t.
- One sub-module: sample_ram.
  - DEPTH x DATA_W, 1 write port, 1 read port.
  - Synchronous read-first, with a read-enable.
  - Its read register is data_out.
  - No reset on the array; reset on the read register only.

Test Plan:
- Basic one-shot: load table[i]=i*100 for i=0..31; len_m1=3, rate_div=0, loop_en=0; pulse start at edge N. Require data_out = 0, 100, 200, 300 at edges N+1..N+4, strobe each cycle, done only at N+4, busy falls at N+5 edge.
- Rate divider: len_m1=1, rate_div=2. Require strobes at edges N+3 and N+6 only, with data_out 0 then 100.
- Loop wrap: len_m1=31, rate_div=0, loop_en=1, run 70 cycles. Require data_out sequence 0..3100 then wrap to 0, no done. Then clear loop_en: done coincides with the next table[31]=3100 strobe.
- Stop and start priority: in RUN after 2 samples, assert stop. Require no strobe/done, busy=0 next edge, data_out held at 100. Then start+stop together in IDLE: require state stays IDLE.
- Write collision: during a looping run, write table[5]=16'hBEEF on the edge table[5] is read. Require the old 500 this pass and BEEF on the next pass.
- Async reset mid-run: drop reset between edges. Require outputs 0 immediately. After release and start with len_m1=0: require table[0] still intact (0).

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR sample source and the FIR filter it feeds.
package fir_pkg;

   localparam int DATA_W = 16;   // sample width, matches FIR_Filter data_in
   localparam int DEPTH  = 32;   // sample table entries
   localparam int ADDR_W = 5;    // log2(DEPTH)
   localparam int DIV_W  = 8;    // sample-rate divider width

   typedef logic [DATA_W-1:0] sample_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } src_state_t;

endpackage

// File: rtl/sample_ram.sv
// Sample table: one write port, one read port, synchronous read-first with read enable.
// The array carries no reset so it keeps its contents across reset; only the
// read register is cleared.
module sample_ram #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);
   import fir_pkg::*;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data_reg;

   // Table write port; no reset so the contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Registered read; a same-edge write to the same entry returns the old value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data_reg <= '0;
      end else if (rd_en) begin
         rd_data_reg <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_reg;

endmodule

// File: rtl/fir_sample_source.sv
// Programmable-rate sample player feeding FIR_Filter data_in from a loadable table.
// Plays len_m1+1 entries, one every rate_div+1 cycles, once or looping.
module fir_sample_source #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5,
   parameter int DIV_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              start,
   input  logic              stop,
   input  logic [ADDR_W-1:0] len_m1,
   input  logic [DIV_W-1:0]  rate_div,
   input  logic              loop_en,
   output logic [DATA_W-1:0] data_out,
   output logic              sample_strobe,
   output logic              busy,
   output logic              done
);
   import fir_pkg::*;

   src_state_t        state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [DIV_W-1:0]  div_cnt_reg, div_cnt_next;
   logic [ADDR_W-1:0] len_reg, len_next;
   logic [DIV_W-1:0]  rate_reg, rate_next;
   logic              strobe_reg, strobe_next;
   logic              done_reg, done_next;
   logic              busy_reg;
   logic              emit;

   // Table; its read register is data_out and only advances when a sample is emitted.
   sample_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (emit),
      .rd_addr (addr_reg),
      .rd_data (data_out)
   );

   // Control and rate-divider registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         addr_reg    <= '0;
         div_cnt_reg <= '0;
         len_reg     <= '0;
         rate_reg    <= '0;
         strobe_reg  <= 1'b0;
         done_reg    <= 1'b0;
         busy_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         addr_reg    <= addr_next;
         div_cnt_reg <= div_cnt_next;
         len_reg     <= len_next;
         rate_reg    <= rate_next;
         strobe_reg  <= strobe_next;
         done_reg    <= done_next;
         busy_reg    <= (state_reg == RUN);
      end
   end

   // Next-state: start/stop handling, rate division and address sequencing.
   always_comb begin
      state_next   = state_reg;
      addr_next    = addr_reg;
      div_cnt_next = div_cnt_reg;
      len_next     = len_reg;
      rate_next    = rate_reg;
      strobe_next  = 1'b0;
      done_next    = 1'b0;
      emit         = 1'b0;
      case (state_reg)
         IDLE: begin
            // stop has priority over a simultaneous start
            if (start && !stop) begin
               state_next   = RUN;
               len_next     = len_m1;
               rate_next    = rate_div;
               addr_next    = '0;
               div_cnt_next = '0;
            end
         end
         RUN: begin
            if (stop) begin
               state_next = IDLE;
            end else if (div_cnt_reg != rate_reg) begin
               div_cnt_next = div_cnt_reg + 1'b1;
            end else begin
               emit         = 1'b1;
               strobe_next  = 1'b1;
               div_cnt_next = '0;
               if (addr_reg == len_reg) begin
                  // loop_en is looked at live, so clearing it ends the current pass
                  if (loop_en) begin
                     addr_next = '0;
                  end else begin
                     done_next  = 1'b1;
                     state_next = IDLE;
                  end
               end else begin
                  addr_next = addr_reg + 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign sample_strobe = strobe_reg;
   assign done          = done_reg;
   assign busy          = busy_reg;

endmodule

// File: tb/tb_fir_sample_source.sv
// Scoreboard bench for fir_sample_source: the driver predicts every strobe
// (edge number, sample value, done flag) from the playback rules and queues it;
// a monitor pops and compares whenever the DUT strobes.
module tb_fir_sample_source;
   import fir_pkg::*;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              wr_en = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic [ADDR_W-1:0] len_m1 = '0;
   logic [DIV_W-1:0]  rate_div = '0;
   logic              loop_en = 1'b0;
   logic [DATA_W-1:0] data_out;
   logic              sample_strobe;
   logic              busy;
   logic              done;

   fir_sample_source #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DIV_W  (DIV_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .start         (start),
      .stop          (stop),
      .len_m1        (len_m1),
      .rate_div      (rate_div),
      .loop_en       (loop_en),
      .data_out      (data_out),
      .sample_strobe (sample_strobe),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   // Number of rising edges so far; after edge N it reads N.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int                at_edge;
      logic [DATA_W-1:0] data;
      logic              done;
   } exp_t;

   exp_t              exp_q[$];
   logic [DATA_W-1:0] ref_tbl [DEPTH];
   int                checks = 0;
   int                errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: sample j of a run started at edge n0 appears at edge
   // n0+(j+1)*(R+1) carrying table[j mod (L+1)]; done_j marks the sample with done.
   function automatic void push_run(input int n0, input int L, input int R,
                                    input int cnt, input int done_j);
      for (int j = 0; j < cnt; j++) begin
         exp_t e;
         e.at_edge = n0 + (j + 1) * (R + 1);
         e.data    = ref_tbl[j % (L + 1)];
         e.done    = (j == done_j);
         exp_q.push_back(e);
      end
   endfunction

   // Monitor: compare every strobe against the head of the queue.
   always @(negedge clk) begin
      if (reset) begin
         if (done) check("done_implies_strobe", {31'd0, sample_strobe}, 32'd1);
         if (sample_strobe) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_strobe: got data %0h at edge %0d, expected no strobe",
                        data_out, cyc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("strobe_edge", cyc, e.at_edge);
               check("data_out", {16'd0, data_out}, {16'd0, e.data});
               check("done", {31'd0, done}, {31'd0, e.done});
               $display("strobe edge %0d data %0h done %0b", cyc, data_out, done);
            end
         end
      end
   end

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic wait_drain(input int max_cycles);
      for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(negedge clk);
      check("drain", exp_q.size(), 0);
   endtask

   task automatic tbl_write(input int a, input logic [DATA_W-1:0] d);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = a[ADDR_W-1:0];
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
      ref_tbl[a] = d;
   endtask

   // Pulse start; returns the edge number at which start was sampled.
   // Afterwards len_m1/rate_div are scrambled to prove they were captured.
   task automatic do_start(input int L, input int R, input logic lp, output int n0);
      @(negedge clk);
      n0       = cyc + 1;
      len_m1   = L[ADDR_W-1:0];
      rate_div = R[DIV_W-1:0];
      loop_en  = lp;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      len_m1   = ADDR_W'($urandom);
      rate_div = DIV_W'($urandom);
      $display("start at edge %0d len_m1 %0d rate_div %0d loop %0b", n0, L, R, lp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_data_out", {16'd0, data_out}, 32'd0);
      check("rst_strobe", {31'd0, sample_strobe}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      reset = 1'b1;

      for (int i = 0; i < DEPTH; i++) tbl_write(i, DATA_W'(i * 100));

      // Basic one-shot
      do_start(3, 0, 1'b0, n0);
      push_run(n0, 3, 0, 4, 3);
      wait_cyc(n0 + 4);
      check("busy_last_sample", {31'd0, busy}, 32'd1);
      wait_cyc(n0 + 5);
      check("busy_fall", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      check("idle_hold", {16'd0, data_out}, 32'd300);
      wait_drain(10);

      // Rate divider
      do_start(1, 2, 1'b0, n0);
      push_run(n0, 1, 2, 2, 1);
      wait_drain(20);
      repeat (5) @(negedge clk);

      // Loop wrap, write collision on entry 5, then loop_en cleared
      do_start(31, 0, 1'b1, n0);
      push_run(n0, 31, 0, 96, 95);
      for (int j = 6; j < 96; j++) if (j % 32 == 5) exp_q[j].data = 16'hBEEF;
      wait_cyc(n0 + 5);
      wr_en   = 1'b1;
      wr_addr = 5'd5;
      wr_data = 16'hBEEF;
      @(negedge clk);
      wr_en = 1'b0;
      ref_tbl[5] = 16'hBEEF;
      wait_cyc(n0 + 70);
      loop_en = 1'b0;
      wait_drain(60);
      repeat (3) @(negedge clk);
      check("loop_end_busy", {31'd0, busy}, 32'd0);

      // Stop mid-run, then start and stop together in IDLE
      do_start(31, 0, 1'b0, n0);
      push_run(n0, 31, 0, 2, -1);
      wait_cyc(n0 + 2);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("stop_no_strobe", {31'd0, sample_strobe}, 32'd0);
      check("stop_no_done", {31'd0, done}, 32'd0);
      check("stop_hold", {16'd0, data_out}, 32'd100);
      @(negedge clk);
      check("stop_busy", {31'd0, busy}, 32'd0);
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("start_stop_idle", {31'd0, busy}, 32'd0);
      end
      check("start_stop_hold", {16'd0, data_out}, 32'd100);
      wait_drain(2);

      // Asynchronous reset mid-run
      do_start(31, 0, 1'b1, n0);
      push_run(n0, 31, 0, 4, -1);
      wait_cyc(n0 + 4);
      #1;
      reset = 1'b0;
      #1;
      check("arst_data_out", {16'd0, data_out}, 32'd0);
      check("arst_strobe", {31'd0, sample_strobe}, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_done", {31'd0, done}, 32'd0);
      check("arst_queue", exp_q.size(), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      do_start(0, 0, 1'b0, n0);
      push_run(n0, 0, 0, 1, 0);
      wait_drain(10);

      // Randomized one-shot runs with random table updates between them
      for (int r = 0; r < 8; r++) begin
         int nw, L, R;
         nw = $urandom_range(0, 4);
         for (int k = 0; k < nw; k++) tbl_write($urandom_range(0, DEPTH - 1), DATA_W'($urandom));
         L = $urandom_range(0, 7);
         R = $urandom_range(0, 3);
         do_start(L, R, 1'b0, n0);
         push_run(n0, L, R, L + 1, L);
         wait_drain((L + 2) * (R + 1) + 5);
         repeat (2) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      check("final_queue", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
